// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch queue bus: imem read port, redirect input, decode handshake
// master is the fetch queue itself; slave is the surrounding memory/decode/execute side.
interface instr_fetch_queue_if #(
  parameter int PC_W    = 64,
  parameter int IMEM_AW = 8,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CW-1:0]      q_count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, q_count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, q_count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC owner and instruction FIFO feeding decode
// Issues one imem read per cycle while queued + in-flight entries leave room in the FIFO.
module instr_fetch_queue #(
  parameter int              PC_W     = 64,
  parameter int              IMEM_AW  = 8,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_queue_if.master   bus
);
  localparam int             AW     = $clog2(DEPTH);
  localparam int             CW     = AW + 1;
  localparam logic [CW:0]    LIMIT  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]  FULL   = CW'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];

  logic [CW:0]     credit;
  logic            issue;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue  = !reset && !bus.redirect_valid && (credit < LIMIT);
    push   = inflight_q && !kill_q && !bus.redirect_valid;
    pop    = (count_q != '0) && bus.out_ready && !bus.redirect_valid;

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    kill_d     = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (bus.redirect_valid) begin
      // Flush wins over any same-cycle pop or arriving response.
      pc_d    = {bus.redirect_pc[PC_W-1:2], 2'b00};
      kill_d  = inflight_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        req_pc_d   = pc_q;
        pc_d       = pc_q + PC_W'(4);
        inflight_d = 1'b1;
      end
      tail_d  = tail_q + AW'(push);
      head_d  = head_q + AW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem_q[tail_q] <= bus.imem_rdata;
      pc_mem_q[tail_q]    <= req_pc_q;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q[IMEM_AW+1:2];
  assign bus.out_valid = (count_q != '0);
  // Empty queue presents zeros so stale storage never leaks to decode.
  assign bus.out_instr = bus.out_valid ? instr_mem_q[head_q] : '0;
  assign bus.out_pc    = bus.out_valid ? pc_mem_q[head_q] : '0;
  assign bus.q_count   = count_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == FULL)));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
// Stimulus pushes hand-computed {pc, instr} pairs; a negedge monitor checks each accepted head.
module tb_instr_fetch_queue;
  logic clk;
  logic reset;

  instr_fetch_queue_if #(.PC_W(64), .IMEM_AW(8), .DEPTH(4)) bus ();

  instr_fetch_queue #(.PC_W(64), .IMEM_AW(8), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp;
  int n_bad;
  logic [63:0] exp_pc [$];
  logic [31:0] exp_ins [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word k holds 32'h00100093 + k, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'h00100093 + 32'(bus.imem_addr);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic expect_item(input logic [63:0] p, input logic [31:0] i);
    exp_pc.push_back(p);
    exp_ins.push_back(i);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (exp_pc.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, 64'(exp_pc.size()), 64'd0);
    exp_pc.delete();
    exp_ins.delete();
  endtask

  task automatic restart(input logic rdy);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready = rdy;
    cyc();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && exp_pc.size() != 0) begin
      chk("out_pc", bus.out_pc, exp_pc.pop_front());
      chk("out_instr", 64'(bus.out_instr), 64'(exp_ins.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata = '0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_q_count", 64'(bus.q_count), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);

    // Basic stream and first-fetch latency.
    bus.out_ready = 1'b1;
    cyc();
    reset = 1'b0;
    expect_item(64'h0, 32'h00100093);
    expect_item(64'h4, 32'h00100094);
    expect_item(64'h8, 32'h00100095);
    expect_item(64'hC, 32'h00100096);
    @(negedge clk);
    chk("first_req", 64'(bus.imem_req), 64'd1);
    chk("first_addr", 64'(bus.imem_addr), 64'd0);
    chk("lat_n", 64'(bus.out_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("lat_n1", 64'(bus.out_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("lat_n2", 64'(bus.out_valid), 64'd1);
    wait_drain("drain_stream");

    // Backpressure: credits stop issue at four.
    cyc();
    restart(1'b0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req) nreq++;
    end
    chk("bp_reqs", 64'(nreq), 64'd4);
    chk("bp_q_count", 64'(bus.q_count), 64'd4);
    chk("bp_no_req", 64'(bus.imem_req), 64'd0);
    expect_item(64'h0, 32'h00100093);
    expect_item(64'h4, 32'h00100094);
    expect_item(64'h8, 32'h00100095);
    expect_item(64'hC, 32'h00100096);
    expect_item(64'h10, 32'h00100097);
    cyc();
    bus.out_ready = 1'b1;
    wait_drain("drain_bp");

    // Redirect with two queued and one in flight.
    cyc();
    restart(1'b0);
    cyc();
    cyc();
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h40;
    @(negedge clk);
    chk("pre_redir_count", 64'(bus.q_count), 64'd2);
    chk("redir_no_req", 64'(bus.imem_req), 64'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    expect_item(64'h40, 32'h001000A3);
    expect_item(64'h44, 32'h001000A4);
    expect_item(64'h48, 32'h001000A5);
    @(negedge clk);
    chk("post_redir_count", 64'(bus.q_count), 64'd0);
    chk("post_redir_valid", 64'(bus.out_valid), 64'd0);
    chk("post_redir_addr", 64'(bus.imem_addr), 64'h10);
    wait_drain("drain_redir");

    // Misaligned target has its low bits forced to zero.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h43;
    cyc();
    bus.redirect_valid = 1'b0;
    expect_item(64'h40, 32'h001000A3);
    expect_item(64'h44, 32'h001000A4);
    @(negedge clk);
    chk("mis_req", 64'(bus.imem_req), 64'd1);
    chk("mis_addr", 64'(bus.imem_addr), 64'h10);
    wait_drain("drain_mis");

    // Redirect racing a pop, then a second redirect: last one wins.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h200;
    @(negedge clk);
    chk("race_valid", 64'(bus.out_valid), 64'd1);
    cyc();
    bus.redirect_pc = 64'h80;
    @(negedge clk);
    chk("race_count", 64'(bus.q_count), 64'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    expect_item(64'h80, 32'h001000B3);
    expect_item(64'h84, 32'h001000B4);
    expect_item(64'h88, 32'h001000B5);
    @(negedge clk);
    chk("race_addr", 64'(bus.imem_addr), 64'h20);
    wait_drain("drain_race");

    // PC wraps modulo 2^64.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    bus.redirect_valid = 1'b0;
    expect_item(64'hFFFF_FFFF_FFFF_FFFC, 32'h00100192);
    expect_item(64'h0, 32'h00100093);
    expect_item(64'h4, 32'h00100094);
    @(negedge clk);
    chk("wrap_addr", 64'(bus.imem_addr), 64'hFF);
    wait_drain("drain_wrap");

    // Reset mid-stream with three queued.
    cyc();
    restart(1'b0);
    cyc();
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_pre_count", 64'(bus.q_count), 64'd3);
    cyc();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    expect_item(64'h0, 32'h00100093);
    expect_item(64'h4, 32'h00100094);
    @(negedge clk);
    chk("mid_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_count", 64'(bus.q_count), 64'd0);
    chk("mid_req", 64'(bus.imem_req), 64'd1);
    chk("mid_addr", 64'(bus.imem_addr), 64'd0);
    wait_drain("drain_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
